// File: rtl/spw_tx_pkg.sv
// spw_tx_pkg: token codes, control-char constants and scheduler states shared by the TX path
package spw_tx_pkg;
  typedef enum logic [2:0] {
    TOK_NULL  = 3'd0,
    TOK_FCT   = 3'd1,
    TOK_DATA  = 3'd2,
    TOK_EOP   = 3'd3,
    TOK_EEP   = 3'd4,
    TOK_TIMEC = 3'd5
  } tok_e;
  typedef enum logic [1:0] {
    S_IDLE,
    S_SELECT,
    S_PRESENT
  } sched_e;
  localparam logic [8:0] EOP_CODE = 9'h100;
  localparam logic [8:0] EEP_CODE = 9'h101;
  // Control chars other than EOP are reported as EEP so a corrupt head still ends the packet
  function automatic tok_e nchar_type(input logic [8:0] d);
    if (!d[8]) return TOK_DATA;
    else if (d == EOP_CODE) return TOK_EOP;
    else return TOK_EEP;
  endfunction
endpackage

// File: rtl/tx_pend_counter.sv
// tx_pend_counter: saturating up/down counter of owed FCTs with synchronous clear
module tx_pend_counter #(
  parameter int W = 3
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         clr_i,
  input  logic         inc_i,
  input  logic         dec_i,
  output logic [W-1:0] cnt_o
);
  logic [W-1:0] cnt_q, cnt_d;
  // Simultaneous inc and dec cancel; inc sticks at all-ones, dec stops at zero
  always_comb
    cnt_d = clr_i ? '0 :
            (inc_i && !dec_i && cnt_q != '1) ? cnt_q + 1'b1 :
            (dec_i && !inc_i && cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
  // Count register
  always_ff @(posedge clk_i)
    if (!rst_ni) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign cnt_o = cnt_q;
endmodule

// File: rtl/tx_char_scheduler.sv
// tx_char_scheduler: picks TIMEC/FCT/N-char/NULL per token slot and hands it to the encoder
module tx_char_scheduler
  import spw_tx_pkg::*;
#(
  parameter int GAP_CYCLES = 3,
  parameter int FCT_PEND_W = 3
) (
  input  logic       pclk_tx,
  input  logic       enable_tx,
  input  logic       send_null_tx,
  input  logic       send_fct_tx,
  input  logic       send_char_tx,
  input  logic [5:0] fct_counter_p,
  input  logic       fct_req,
  input  logic       tick_tx,
  input  logic [7:0] time_in,
  input  logic       data_valid_tx,
  input  logic [8:0] data_tx,
  output logic       data_rd_tx,
  output logic       tok_valid,
  input  logic       tok_ready,
  output logic [2:0] tok_type,
  output logic [7:0] tok_data,
  output logic       char_sent,
  output logic       fct_ack
);
  localparam int GW = GAP_CYCLES > 0 ? $clog2(GAP_CYCLES + 1) : 1;
  sched_e state_q, state_d;
  tok_e tok_type_q, tok_type_d;
  logic [7:0] tok_data_q, tok_data_d, time_q, time_d;
  logic tick_pend_q, tick_pend_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [FCT_PEND_W-1:0] fct_pend;
  logic xfer, nchar_xfer;
  // A dropped link kills the token immediately, so nothing counts as transferred
  assign tok_valid  = state_q == S_PRESENT && send_null_tx;
  assign xfer       = tok_valid && tok_ready;
  assign nchar_xfer = xfer && tok_type_q inside {TOK_DATA, TOK_EOP, TOK_EEP};
  assign data_rd_tx = nchar_xfer;
  assign char_sent  = nchar_xfer;
  assign fct_ack    = xfer && tok_type_q == TOK_FCT;
  assign tok_type   = tok_type_q;
  assign tok_data   = tok_data_q;
  tx_pend_counter #(.W(FCT_PEND_W)) u_fct_pend (
    .clk_i (pclk_tx),
    .rst_ni(enable_tx),
    .clr_i (!send_null_tx),
    .inc_i (fct_req),
    .dec_i (fct_ack),
    .cnt_o (fct_pend)
  );
  // Slot FSM, token choice latched in SELECT, and time-code / gap bookkeeping
  always_comb begin
    state_d    = state_q;
    tok_type_d = tok_type_q;
    tok_data_d = tok_data_q;
    unique case (state_q)
      S_IDLE: state_d = S_SELECT;
      S_SELECT: begin
        state_d = S_PRESENT;
        if (tick_pend_q && send_char_tx) begin
          tok_type_d = TOK_TIMEC;
          tok_data_d = time_q;
        end else if (fct_pend != '0 && send_fct_tx) begin
          tok_type_d = TOK_FCT;
          tok_data_d = '0;
        end else if (send_char_tx && data_valid_tx && fct_counter_p != '0 && gap_q == '0) begin
          tok_type_d = nchar_type(data_tx);
          tok_data_d = data_tx[8] ? 8'h00 : data_tx[7:0];
        end else begin
          tok_type_d = TOK_NULL;
          tok_data_d = '0;
        end
      end
      S_PRESENT: state_d = tok_ready ? S_SELECT : S_PRESENT;
      default: state_d = S_IDLE;
    endcase
    if (!send_null_tx) state_d = S_IDLE;
    time_d      = tick_tx ? time_in : time_q;
    tick_pend_d = !send_null_tx ? 1'b0 : tick_tx ? 1'b1 :
                  (xfer && tok_type_q == TOK_TIMEC) ? 1'b0 : tick_pend_q;
    gap_d       = !send_null_tx ? '0 : nchar_xfer ? GW'(GAP_CYCLES) :
                  gap_q != '0 ? gap_q - 1'b1 : gap_q;
  end
  // State and token registers
  always_ff @(posedge pclk_tx)
    if (!enable_tx) begin
      state_q     <= S_IDLE;
      tok_type_q  <= TOK_NULL;
      tok_data_q  <= '0;
      time_q      <= '0;
      tick_pend_q <= 1'b0;
      gap_q       <= '0;
    end else begin
      state_q     <= state_d;
      tok_type_q  <= tok_type_d;
      tok_data_q  <= tok_data_d;
      time_q      <= time_d;
      tick_pend_q <= tick_pend_d;
      gap_q       <= gap_d;
    end
endmodule

// File: doc/tx_char_scheduler.md
# tx_char_scheduler

Transmit-side token scheduler for the SpaceWire link (ECSS-E-ST-50-12C). It sits directly downstream of the FCT credit counter and directly upstream of the bit encoder. Each token slot it chooses among time-code, FCT, N-char and NULL according to link state, pending FCT requests, host data availability and the credit count `fct_counter_p`. It returns `char_sent` to the credit counter for every N-char transmitted.

## Interface
- `GAP_CYCLES`, 3: minimum number of idle cycles between the `char_sent` pulse and the next N-char issue. This covers the credit counter's decrement-and-rearm latency.
- `FCT_PEND_W`, 3: width of the pending-FCT counter; it saturates at 2^W-1.
- `pclk_tx`  in  1: TX clock; all logic runs on its rising edge.
- `enable_tx`  in  1: reset, synchronous, active-low.
- `send_null_tx`  in  1: link may transmit (NULLs allowed).
- `send_fct_tx`  in  1: FCTs allowed (Connecting/Run).
- `send_char_tx`  in  1: N-chars and time-codes allowed (Run).
- `fct_counter_p`  in  6: available TX credits, from the credit counter.
- `fct_req`  in  1: one-cycle pulse; the RX buffer has room for 8 more chars, so one FCT is owed.
- `tick_tx`  in  1: one-cycle pulse; send a time-code.
- `time_in`  in  8: time-code value, sampled when `tick_tx` is high.
- `data_valid_tx`  in  1: show-ahead host FIFO is non-empty.
- `data_tx`  in  9: FIFO head. Bit 8 is the control flag. Values 0x100 = EOP, 0x101 = EEP.
- `data_rd_tx`  out  1: FIFO pop pulse.
- `tok_valid`  out  1: token presented to the encoder.
- `tok_ready`  in  1: encoder accepts the token. Transfer happens when both `tok_valid` and `tok_ready` are high.
- `tok_type`  out  3: token type.
- `tok_data`  out  8: payload for DATA and TIMEC tokens, otherwise 0.
- `char_sent`  out  1: one-cycle pulse per N-char transferred.
- `fct_ack`  out  1: one-cycle pulse per FCT transferred.

## Operation
- States:
  - IDLE: `send_null_tx`=0.
  - SELECT: choose the next token.
  - PRESENT: `tok_valid`=1, hold until transfer.
- Transitions:
  - IDLE→SELECT when `send_null_tx`=1.
  - SELECT→PRESENT always, in 1 cycle.
  - PRESENT→SELECT on transfer.
  - Any state→IDLE when `send_null_tx`=0.
- Priority evaluated in SELECT, highest first:
  1. TIMEC: `tick_pend` && `send_char_tx`.
  2. FCT: `fct_pend`≠0 && `send_fct_tx`.
  3. N-char: `send_char_tx` && `data_valid_tx` && `fct_counter_p`≠0 && `gap_cnt`=0.
  4. NULL.
- N-char mapping:
  - `data_tx[8]`=0 → DATA, `tok_data`=`data_tx[7:0]`.
  - 0x100 → EOP.
  - 0x101 → EEP.
  - Any other value with bit 8 set → EEP (error char).
- Token fields are latched in SELECT and held stable while `tok_valid`=1.
- On N-char transfer:
  - `data_rd_tx`=1 and `char_sent`=1 in the same cycle as the transfer.
  - `gap_cnt` loads `GAP_CYCLES`, then decrements to 0 once per cycle.
- `fct_pend` behaviour:
  - Increments on `fct_req`, saturating at the maximum.
  - Decrements on FCT transfer.
  - If both happen in the same cycle, the count is unchanged.
- `tick_pend` behaviour:
  - Set by `tick_tx`, which also latches `time_in`.
  - A second tick while pending overwrites the value and leaves one tick pending.
  - Cleared on TIMEC transfer; a simultaneous new tick re-arms it.
- `send_null_tx` falling:
  - Abort any token in flight.
  - Clear `fct_pend`, `tick_pend` and `gap_cnt`.
  - No `char_sent` and no `data_rd_tx` for the aborted token.
- `send_char_tx` falling while a DATA token is presented: the token still completes on `tok_ready`.

## Timing
- Reset (`enable_tx`=0 at an edge):
  - State IDLE.
  - All outputs 0.
  - `fct_pend`=0, `tick_pend`=0, `gap_cnt`=0.
- Latency: a request visible in SELECT at cycle t gives `tok_valid` at t+1.
- Token issue rate: at most one token per 2 cycles (SELECT + PRESENT).
- `char_sent` spacing: pulses are ≥ `GAP_CYCLES`+1 cycles apart.
- `fct_counter_p` freshness: the value is sampled in SELECT only. The gap guarantees the credit counter's decrement is already visible.

## Structure
- Shared package `spw_tx_pkg`:
  - Token enum: NULL=0, FCT=1, DATA=2, EOP=3, EEP=4, TIMEC=5.
  - Constants EOP_CODE=9'h100 and EEP_CODE=9'h101.
  - Scheduler state enum.
- Sub-module `tx_pend_counter`: the saturating up/down `fct_pend` counter with clear.

## Test plan
- Reset check: `enable_tx`=0 for 2 cycles, then `send_null_tx`=1 only → all outputs 0 during reset, then continuous NULL tokens and no `char_sent`.
- Credit gating: Run, `fct_counter_p`=0, FIFO holds 0x041 → NULLs only. Set `fct_counter_p`=8 → DATA 0x41 transferred, `data_rd_tx` and `char_sent` pulse once.
- Priority: in one cycle `tick_tx` with `time_in`=0x2A, `fct_req`, and FIFO valid → order TIMEC 0x2A, then FCT with `fct_ack`, then DATA.
- Saturation: 9 `fct_req` pulses with `send_fct_tx`=0 → once enabled, exactly 7 FCT tokens.
- Gap: FIFO holds 3 chars, credits 56, `tok_ready`=1 → `char_sent` pulses ≥4 cycles apart, with NULLs between.
- Abort: drop `send_null_tx` while DATA is presented and `tok_ready`=0 → `tok_valid`=0 next cycle, no pop, FIFO head unchanged.
